mdio_arbiter: RTL
=================

MDIO_ARBITER -- requirements
Module: mdio_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, max cycles from command issue to completion flag.
REQ-003 SHALL have parameter GAP_CYCLES, default 2, idle cycles between transactions (>=1).
REQ-004 SHALL have port i_clk, input, 1, single clock for all logic.
REQ-005 SHALL have port i_reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port i_req, input, N_REQ, level request per requester.
REQ-007 SHALL have port i_req_cmd, input, N_REQ*32, 32-bit MDIO frame per requester, slice k = bits [32k+31:32k].
REQ-008 SHALL have port o_done, output, N_REQ, one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port o_rsp_data, output, 16, read data of the last completed transaction.
REQ-010 SHALL have port o_rsp_err, output, 1, timeout flag of the last completed transaction.
REQ-011 SHALL have port o_busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port o_new_cmd, output, 1, one-cycle start pulse to the MDIO master.
REQ-013 SHALL have port o_cmd, output, 32, frame driven to the MDIO master.
REQ-014 SHALL have ports i_data_written_flag (input, 1), i_data_read_flag (input, 1) and i_r_register_data (input, 16), completion status from the MDIO master.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT, RESP and GAP.
REQ-016 SHALL go IDLE->ISSUE on any i_req bit high at a clock edge, latching the grant index and that requester's i_req_cmd into o_cmd.
REQ-017 SHALL assert o_new_cmd for exactly one cycle in ISSUE, i.e. one cycle after the request is sampled, then go to WAIT.
REQ-018 SHALL hold o_cmd stable from ISSUE until the next grant.
REQ-019 SHALL treat o_cmd bit 3 as direction: 1 = write, 0 = read.
REQ-020 SHALL grant round-robin: search starts at (last grant + 1) mod N_REQ; after reset, requester 0 has highest priority.
REQ-021 SHALL run a WAIT cycle counter; a write completes on i_data_written_flag, a read on i_data_read_flag, and the flag opposite to the direction is ignored.
REQ-022 SHALL on read completion capture i_r_register_data into o_rsp_data; on write completion set o_rsp_data to 0; in both cases clear o_rsp_err.
REQ-023 SHALL on the counter reaching TIMEOUT_CYCLES without a matching flag set o_rsp_err=1 and o_rsp_data=0.
REQ-024 SHALL give a completion flag priority over timeout when both occur in the same cycle.
REQ-025 SHALL in RESP pulse o_done[grant] for one cycle, then go to GAP.
REQ-026 SHALL hold o_rsp_data and o_rsp_err until the next RESP.
REQ-027 SHALL stay in GAP for GAP_CYCLES cycles, then go to IDLE; requests are not sampled in ISSUE, WAIT, RESP or GAP.
REQ-028 SHALL continue a transaction whose requester drops i_req mid-transaction; o_done is still pulsed.
REQ-029 SHALL require requesters to hold i_req_cmd stable while i_req is high; i_req remaining high after o_done starts a new request.

Reset
REQ-030 SHALL on i_reset, at any time including mid-transaction, immediately force state IDLE, o_new_cmd=0, o_cmd=0, o_done=0, o_rsp_data=0, o_rsp_err=0, o_busy=0, counters=0 and last grant = N_REQ-1.
REQ-031 SHALL not complete or signal an aborted transaction after reset release.

Structure
REQ-032 SHALL place the state encoding, CMD_WR_BIT=3, CMD_W=32 and DATA_W=16 in shared package mdio_pkg.
REQ-033 SHALL implement grant selection in sub-module rr_arbiter (inputs: request vector, last grant; output: grant index and valid).

Verification
REQ-034 SHALL cover: i_req=001, cmd bit3=0, read flag after 20 cycles with data 0xBEEF -> o_new_cmd one cycle after request, o_done=001, o_rsp_data=0xBEEF, o_rsp_err=0.
REQ-035 SHALL cover: i_req=111 held continuously -> grants in order 0,1,2,0, with at least GAP_CYCLES cycles of o_busy idle-state spacing between o_done pulses.
REQ-036 SHALL cover: write command with no flag -> o_done after TIMEOUT_CYCLES, o_rsp_err=1, o_rsp_data=0.
REQ-037 SHALL cover: read flag in the exact timeout cycle -> o_rsp_err=0 and data captured.
REQ-038 SHALL cover: i_reset pulsed during WAIT -> all outputs 0 and no o_done after release; next grant goes to requester 0.
REQ-039 SHALL cover: write command receiving only i_data_read_flag -> flag ignored and completion by timeout.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO arbiter slice.
//   state_e    : arbiter FSM state encoding
//   CMD_W      : MDIO frame width
//   DATA_W     : MDIO register data width
//   CMD_WR_BIT : frame bit selecting write (1) or read (0)
package mdio_pkg;

  localparam int unsigned CMD_W      = 32;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned CMD_WR_BIT = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

endpackage

// File: rtl/mdio_arbiter_rr.sv
// Round-robin grant selection (module rr_arbiter).
//   req   : request vector, one bit per requester
//   last  : index of the previous grant; search starts one above it
//   grant : selected requester index (valid only when valid=1)
//   valid : at least one request is pending
module rr_arbiter #(
  parameter int unsigned N_REQ = 3,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  // Walk the requesters starting at last+1, wrapping modulo N_REQ.
  always_comb begin
    int unsigned s;
    logic [IDX_W-1:0] idx;
    grant = '0;
    valid = 1'b0;
    s     = 0;
    idx   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      s = 32'(last) + i;
      if (s >= N_REQ) s = s - N_REQ;
      idx = IDX_W'(s);
      if (!valid && req[idx]) begin
        valid = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/mdio_arbiter.sv
// Arbitrates several requesters onto one MDIO master, one transaction at a time.
//   i_clk, i_reset        : clock, async active-high reset
//   i_req, i_req_cmd      : per-requester level request and 32-bit frame
//   o_done                : one-cycle completion pulse to the granted requester
//   o_rsp_data, o_rsp_err : result of the last completed transaction
//   o_busy                : high whenever the FSM is not idle
//   o_new_cmd, o_cmd      : start pulse and frame to the MDIO master
//   i_data_written_flag, i_data_read_flag, i_r_register_data : master status
module mdio_arbiter
  import mdio_pkg::*;
#(
  parameter int unsigned N_REQ          = 3,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*CMD_W-1:0]   i_req_cmd,
  output logic [N_REQ-1:0]         o_done,
  output logic [DATA_W-1:0]        o_rsp_data,
  output logic                     o_rsp_err,
  output logic                     o_busy,
  output logic                     o_new_cmd,
  output logic [CMD_W-1:0]         o_cmd,
  input  logic                     i_data_written_flag,
  input  logic                     i_data_read_flag,
  input  logic [DATA_W-1:0]        i_r_register_data
);

  localparam int unsigned IDX_W   = $clog2(N_REQ);
  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e           state;
  logic [IDX_W-1:0] grant_idx;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] arb_grant;
  logic             arb_valid;
  logic [CMD_W-1:0] cmd_arr [N_REQ];
  logic             is_wr;
  logic             flag_hit;
  logic [N_REQ-1:0] done_vec;

  // Unpack the flat command bus into one frame per requester.
  for (genvar g = 0; g < N_REQ; g++) begin : g_cmd
    assign cmd_arr[g] = i_req_cmd[g*CMD_W +: CMD_W];
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (i_req),
    .last  (grant_idx),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  // Only the flag matching the latched direction can complete a transaction.
  assign is_wr    = o_cmd[CMD_WR_BIT];
  assign flag_hit = is_wr ? i_data_written_flag : i_data_read_flag;
  assign done_vec = N_REQ'(1) << grant_idx;

  // Transaction FSM; all outputs are registered alongside the state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      grant_idx  <= IDX_W'(N_REQ - 1);
      cnt        <= '0;
      o_new_cmd  <= 1'b0;
      o_cmd      <= '0;
      o_done     <= '0;
      o_rsp_data <= '0;
      o_rsp_err  <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_new_cmd <= 1'b0;
      o_done    <= '0;
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_idx <= arb_grant;
            o_cmd     <= cmd_arr[arb_grant];
            o_new_cmd <= 1'b1;
            o_busy    <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A flag in the final counted cycle still wins over the timeout.
          if (flag_hit) begin
            o_rsp_data <= is_wr ? '0 : i_r_register_data;
            o_rsp_err  <= 1'b0;
            o_done     <= done_vec;
            state      <= ST_RESP;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            o_rsp_data <= '0;
            o_rsp_err  <= 1'b1;
            o_done     <= done_vec;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          cnt   <= '0;
          state <= ST_GAP;
        end
        ST_GAP: begin
          if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
